// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan code set 2 key decoder.
// Parser states, prefix bytes, discard list and game-key map.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0,
    ST_SKIP
  } ps2_state_e;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } key_evt_t;

  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_F0 = 8'hF0;
  localparam logic [7:0] PFX_E1 = 8'hE1;

  // Bytes trailing E1 in the Pause sequence
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ONE   = 8'h16;
  localparam logic [7:0] SC_TWO   = 8'h1E;

  localparam int KEY_ENTER = 0;
  localparam int KEY_SPACE = 1;
  localparam int KEY_ONE   = 2;
  localparam int KEY_TWO   = 3;

  // Keyboard status/ack bytes that never start a key sequence
  function automatic logic is_discard(input logic [7:0] b);
    logic d;
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA,
      8'hFC, 8'hFD, 8'hFE, 8'hFF: d = 1'b1;
      default:                    d = 1'b0;
    endcase
    return d;
  endfunction

  // One-hot game key hit; Enter matches with or without E0
  function automatic logic [3:0] key_mask(
    input logic [7:0] code,
    input logic       ext
  );
    logic [3:0] m;
    m = '0;
    if (code == SC_ENTER) begin
      m[KEY_ENTER] = 1'b1;
    end else if (!ext) begin
      if (code == SC_SPACE) m[KEY_SPACE] = 1'b1;
      if (code == SC_ONE)   m[KEY_ONE]   = 1'b1;
      if (code == SC_TWO)   m[KEY_TWO]   = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO of key events {brk, ext, code}.
// Head is read straight from register storage; push while full needs a pop.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       push,
  input  key_evt_t                   wdata,
  input  logic                       pop,
  output key_evt_t                   rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  key_evt_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage, wrapping pointers and occupancy
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Scan code set 2 parser: make/break/E0/Pause into an event FIFO,
// plus held/pressed state for Enter, Space, 1 and 2.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter bit FILTER_REPEAT  = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_en,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       overflow,
  output logic       seq_error,
  output logic [3:0] key_held,
  output logic [3:0] key_pressed
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_e    state, state_n;
  logic [2:0]    skip, skip_n;
  logic [TW-1:0] idle_cnt;
  logic          ev_done;
  key_evt_t      ev;
  key_evt_t      head;
  logic [3:0]    mask;
  logic [3:0]    held_n;
  logic          push_req;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  // Next parser state and completed event for the byte on rx_data
  always_comb begin
    state_n = state;
    skip_n  = skip;
    ev_done = 1'b0;
    ev      = '{brk: 1'b0, ext: 1'b0, code: rx_data};
    if (rx_en) begin
      unique case (state)
        ST_IDLE: begin
          if (rx_data == PFX_E0) begin
            state_n = ST_E0;
          end else if (rx_data == PFX_F0) begin
            state_n = ST_F0;
          end else if (rx_data == PFX_E1) begin
            state_n = ST_SKIP;
            skip_n  = PAUSE_SKIP;
          end else begin
            ev_done = !is_discard(rx_data);
          end
        end
        ST_E0: begin
          ev.ext = 1'b1;
          if (rx_data == PFX_F0) begin
            state_n = ST_E0F0;
          end else begin
            state_n = ST_IDLE;
            ev_done = (rx_data != PFX_E0) && (rx_data != PFX_E1);
          end
        end
        ST_F0, ST_E0F0: begin
          ev.ext  = (state == ST_E0F0);
          ev.brk  = 1'b1;
          state_n = ST_IDLE;
          ev_done = (rx_data != PFX_E0) && (rx_data != PFX_F0) &&
                    (rx_data != PFX_E1);
        end
        ST_SKIP: begin
          skip_n = skip - 1'b1;
          if (skip == 3'd1) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign mask   = key_mask(ev.code, ev.ext);
  assign held_n = !ev_done ? key_held :
                  ev.brk   ? (key_held & ~mask) :
                             (key_held | mask);

  assign push_req = ev_done &&
                    !(FILTER_REPEAT && !ev.brk && |(mask & key_held));
  assign pop      = evt_valid && evt_ready;

  // Parser state, Pause skip count and mid-sequence timeout
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= ST_IDLE;
      skip      <= '0;
      idle_cnt  <= '0;
      seq_error <= 1'b0;
    end else begin
      seq_error <= 1'b0;
      skip      <= skip_n;
      if (state == ST_IDLE || rx_en) begin
        idle_cnt <= '0;
        state    <= state_n;
      end else if (idle_cnt == TO_LAST) begin
        idle_cnt  <= '0;
        state     <= ST_IDLE;
        seq_error <= 1'b1;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  // Game key levels, press pulses and sticky drop flag
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_held    <= '0;
      key_pressed <= '0;
      overflow    <= 1'b0;
    end else begin
      key_held    <= held_n;
      key_pressed <= held_n & ~key_held;
      if (push_req && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .push     (push_req),
    .wdata    (ev),
    .pop      (pop),
    .rdata    (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign evt_valid = !fifo_empty;
  assign evt_code  = head.code;
  assign evt_ext   = head.ext;
  assign evt_break = head.brk;

  // Full flag and occupancy must never disagree
  always_ff @(posedge CLOCK_50) begin
    if (!reset) assert (fifo_full == (fifo_count == CW'(FIFO_DEPTH)));
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed sequences plus random byte streams
// compared every cycle against a queue-based model of the key decoder.
module tb_ps2_key_decoder;

  localparam int DEPTH = 4;
  localparam int TO    = 64;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_en;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       overflow;
  logic       seq_error;
  logic [3:0] key_held;
  logic [3:0] key_pressed;

  ps2_key_decoder #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO),
    .FILTER_REPEAT  (1'b1)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_en       (rx_en),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_code    (evt_code),
    .evt_ext     (evt_ext),
    .evt_break   (evt_break),
    .overflow    (overflow),
    .seq_error   (seq_error),
    .key_held    (key_held),
    .key_pressed (key_pressed)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_chk  = 0;
  int n_fail = 0;

  logic [9:0] m_q[$];
  logic [7:0] m_pend[$];
  logic [3:0] m_held;
  logic [3:0] m_pressed;
  bit         m_ovf;
  bit         m_serr;
  int         m_skip;
  int         m_idle;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  function automatic logic [3:0] m_key(input logic [7:0] c, input bit ext);
    if (c == 8'h5A) return 4'b0001;
    if (ext)        return 4'b0000;
    if (c == 8'h29) return 4'b0010;
    if (c == 8'h16) return 4'b0100;
    if (c == 8'h1E) return 4'b1000;
    return 4'b0000;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_pend.delete();
    m_held    = '0;
    m_pressed = '0;
    m_ovf     = 0;
    m_serr    = 0;
    m_skip    = 0;
    m_idle    = 0;
  endtask

  // One byte through the sequence model: prefixes accumulate in m_pend
  task automatic m_byte(input logic [7:0] b, output bit done,
                        output logic [9:0] e);
    bit ext;
    bit brk;
    done = 0;
    e    = '0;
    if (m_skip > 0) begin
      m_skip--;
    end else if (m_pend.size() == 0) begin
      if (b == 8'hE0 || b == 8'hF0) m_pend.push_back(b);
      else if (b == 8'hE1) m_skip = 7;
      else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA,
                           8'hFC, 8'hFD, 8'hFE, 8'hFF})) begin
        done = 1;
        e    = {2'b00, b};
      end
    end else begin
      ext = (m_pend[0] == 8'hE0);
      brk = (m_pend[m_pend.size()-1] == 8'hF0);
      if (m_pend.size() == 1 && ext && b == 8'hF0) begin
        m_pend.push_back(b);
      end else begin
        m_pend.delete();
        if (!(b inside {8'hE0, 8'hF0, 8'hE1})) begin
          done = 1;
          e    = {brk, ext, b};
        end
      end
    end
  endtask

  // Compare current outputs, then apply inputs for one clock to DUT and model
  task automatic step(input bit en, input logic [7:0] b, input bit rdy,
                      input bit rst);
    bit         busy;
    bit         pop;
    bit         done;
    logic [9:0] e;
    logic [3:0] nh;
    logic [3:0] mk;
    check("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0)
      check("evt_head", 32'({evt_break, evt_ext, evt_code}), 32'(m_q[0]));
    check("key_held", 32'(key_held), 32'(m_held));
    check("key_pressed", 32'(key_pressed), 32'(m_pressed));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("seq_error", 32'(seq_error), 32'(m_serr));
    reset     = rst;
    rx_en     = en;
    rx_data   = b;
    evt_ready = rdy;
    if (rst) begin
      m_reset();
    end else begin
      busy   = (m_pend.size() > 0) || (m_skip > 0);
      pop    = (m_q.size() > 0) && rdy;
      done   = 0;
      e      = '0;
      nh     = m_held;
      m_serr = 0;
      if (en) begin
        m_idle = 0;
        m_byte(b, done, e);
      end else if (busy) begin
        m_idle++;
        if (m_idle == TO) begin
          m_idle = 0;
          m_pend.delete();
          m_skip = 0;
          m_serr = 1;
        end
      end else begin
        m_idle = 0;
      end
      if (pop) void'(m_q.pop_front());
      if (done) begin
        mk = m_key(e[7:0], e[8]);
        nh = e[9] ? (m_held & ~mk) : (m_held | mk);
        if (e[9] || (mk & m_held) == 0) begin
          if (m_q.size() < DEPTH) m_q.push_back(e);
          else m_ovf = 1;
        end
      end
      m_pressed = nh & ~m_held;
      m_held    = nh;
    end
    @(posedge CLOCK_50);
    #1;
  endtask

  // rmode: 0 never ready, 1 always ready, 2 random ready
  function automatic bit pick_rdy(input int rmode);
    if (rmode == 2) return ($urandom_range(0, 2) != 0);
    return (rmode == 1);
  endfunction

  task automatic send(input logic [7:0] b, input int gap, input int rmode);
    step(1, b, pick_rdy(rmode), 0);
    for (int i = 0; i < gap; i++) step(0, 8'h00, pick_rdy(rmode), 0);
  endtask

  task automatic idle(input int n, input int rmode);
    for (int i = 0; i < n; i++) step(0, 8'h00, pick_rdy(rmode), 0);
  endtask

  task automatic send_seq(input logic [7:0] s[$], input int rmode);
    foreach (s[i]) send(s[i], $urandom_range(0, 2), rmode);
  endtask

  logic [7:0] pool [8] = '{8'h5A, 8'h29, 8'h16, 8'h1E,
                           8'h1C, 8'h32, 8'h21, 8'h24};

  initial begin
    logic [7:0] c;
    reset     = 1'b1;
    rx_en     = 1'b0;
    rx_data   = '0;
    evt_ready = 1'b0;
    m_reset();
    repeat (2) @(posedge CLOCK_50);
    #1;
    step(0, 8'h00, 0, 0);

    send_seq('{8'h29}, 0);
    idle(3, 0);
    send_seq('{8'hF0, 8'h29}, 0);
    idle(3, 1);

    send_seq('{8'hE0, 8'h5A}, 0);
    send_seq('{8'hE0, 8'hF0, 8'h5A}, 0);
    idle(4, 1);

    send_seq('{8'h16, 8'h16, 8'h16, 8'hF0, 8'h16}, 0);
    idle(4, 1);

    send_seq('{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24}, 0);
    idle(2, 0);
    idle(6, 1);
    step(0, 8'h00, 0, 1);
    send_seq('{8'h1C, 8'h32, 8'h21, 8'h23}, 0);
    step(1, 8'h24, 1, 0);
    idle(6, 1);

    send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77}, 1);
    send_seq('{8'h1E}, 1);
    idle(3, 1);

    send(8'hF0, 0, 1);
    idle(TO + 4, 1);
    send_seq('{8'h29}, 1);
    idle(3, 1);

    send(8'hE0, 1, 1);
    step(0, 8'h00, 1, 1);
    send_seq('{8'h5A}, 1);
    idle(3, 1);

    back_to_back: for (int i = 0; i < 6; i++) step(1, pool[i], 0, 0);
    idle(8, 1);

    for (int t = 0; t < 400; t++) begin
      c = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 7)];
      case ($urandom_range(0, 7))
        0, 1: send_seq('{c}, 2);
        2:    send_seq('{8'hF0, c}, 2);
        3:    send_seq('{8'hE0, c}, 2);
        4:    send_seq('{8'hE0, 8'hF0, c}, 2);
        5:    send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14,
                         8'hF0, 8'h77}, 2);
        6:    send_seq('{8'($urandom)}, 2);
        default: begin
          if ($urandom_range(0, 3) == 0) begin
            send(8'hE0, 0, 2);
            idle(TO + $urandom_range(0, 3) - 2, 2);
          end else begin
            idle($urandom_range(0, 5), 2);
          end
        end
      endcase
      if ($urandom_range(0, 150) == 0) step(0, 8'h00, 0, 1);
    end
    idle(8, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Consumes the raw byte stream from the PS/2 controller (`received_data` / `received_data_en`) and parses scan code set 2 sequences: make, break (`F0`), extended (`E0`) and the Pause sequence (`E1`). It emits one complete key event per sequence into a small FIFO with a valid/ready interface. It also keeps held-state and single-cycle press pulses for the four game keys: Enter, Space, 1 and 2. It sits directly downstream of the PS/2 controller and feeds the benchmark game logic.

## Interface
- `FIFO_DEPTH`, default 4: event FIFO depth; must be a power of 2 and ≥ 2.
- `TIMEOUT_CYCLES`, default 100000: idle cycles allowed inside an unfinished sequence before the parser aborts (2 ms at 50 MHz).
- `FILTER_REPEAT`, default 1: when 1, typematic repeat makes of a key already held are not pushed to the FIFO.
- `CLOCK_50`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `rx_data`  in  8  byte from the controller.
- `rx_en`  in  1  single-cycle strobe marking `rx_data` valid.
- `evt_valid`  out  1  FIFO non-empty.
- `evt_ready`  in  1  consumer pops the head when `evt_valid && evt_ready`.
- `evt_code`  out  8  scan code at the head.
- `evt_ext`  out  1  head event had the `E0` prefix.
- `evt_break`  out  1  head event is a release.
- `overflow`  out  1  sticky; set when an event is dropped because the FIFO is full.
- `seq_error`  out  1  one-cycle pulse on timeout abort.
- `key_held`  out  4  {two, one, space, enter}; level while the key is down.
- `key_pressed`  out  4  same order; one-cycle pulse on the 0→1 transition of `key_held`.

## Operation
- **Parser states:** IDLE, E0, F0, E0F0, SKIP.
- **IDLE:**
  - `E0` → E0; `F0` → F0; `E1` → SKIP with the skip counter set to 7.
  - Bytes `00 AA EE FA FC FD FE FF` are discarded.
  - Any other byte completes a make event {code, ext=0, brk=0}.
- **E0:**
  - `F0` → E0F0.
  - `E0`/`E1` → IDLE, byte discarded.
  - Any other byte completes {code, ext=1, brk=0}.
- **F0:** a byte completes {code, 0, 1}; `E0`/`F0`/`E1` → IDLE, discarded.
- **E0F0:** a byte completes {code, 1, 1}; `E0`/`F0`/`E1` → IDLE, discarded.
- **SKIP:** each byte decrements the counter; when it reaches 0 → IDLE. No event is produced.
- **Timeout:**
  - In any state except IDLE, a counter increments each cycle without `rx_en` and clears on `rx_en`.
  - When it reaches `TIMEOUT_CYCLES` → IDLE and `seq_error` pulses for one cycle.
- **Key map** (ext=0 unless noted):
  - Enter = `5A` (ext 0 or 1)
  - Space = `29`
  - 1 = `16`
  - 2 = `1E`
- **Key state:** a completed make sets `key_held[i]`; a completed break clears it.
- **FIFO push:**
  - Every completed event is pushed, except when `FILTER_REPEAT`=1 and it is a make for a mapped key already held.
  - Unmapped repeats are always pushed.
- **Push when full:** the event is dropped and `overflow` sets. Key state still updates.
- **Simultaneous pop and push when full:** both occur; no drop.
- **Reset:**
  - All outputs reset to 0, FIFO empty, parser in IDLE.
  - Reset mid-sequence discards the partial sequence.

## Timing
- `rx_en` in cycle N completing an event:
  - `key_held` and `key_pressed` update in N+1.
  - The event appears at the FIFO head in N+1 if the FIFO was empty (`evt_valid` high in N+1).
- Head outputs are registered from FIFO storage and remain stable while `evt_valid && !evt_ready`.
- A pop in cycle M exposes the next entry in M+1.
- Occupancy uses a `log2(FIFO_DEPTH)+1`-bit count; pointers wrap modulo `FIFO_DEPTH`.
- Back-to-back `rx_en` strobes are supported (the controller produces at most one per ~11 PS/2 clocks).

## Structure
- Shared package `ps2_pkg`:
  - parser state enum
  - prefix constants `E0`, `F0`, `E1`
  - discard-byte list
  - key-map scan codes
  - key index constants
- One sub-module: `ps2_event_fifo`, a parameterised synchronous FIFO of 10-bit entries {brk, ext, code} with full/empty/count.
- Parser, timeout counter and key-state logic live in the top module.

## Test plan
- **Make/break:** `29`, then `F0 29` → event {29,0,0} then {29,0,1}; `key_held[1]` high between them; `key_pressed[1]` pulses once.
- **Extended:** `E0 5A`, `E0 F0 5A` → events {5A,1,0}, {5A,1,1}; `key_held[0]` follows.
- **Repeat filter:** `16 16 16 F0 16` with `FILTER_REPEAT`=1 → FIFO holds 2 events; one `key_pressed[2]` pulse.
- **Overflow:** `evt_ready`=0, five makes `1C 32 21 23 24` → 4 entries, `overflow`=1. Same test with pop and push in the same cycle when full → no drop.
- **Pause:** `E1 14 77 E1 F0 14 F0 77` → no events, parser back in IDLE; a following `1E` yields {1E,0,0}.
- **Timeout/reset:** `F0` then 100000 idle cycles → `seq_error` pulse; a following `29` is a make. Reset asserted after `E0` → next `5A` yields ext=0.
